pipelined_data_mem: RTL and testbench

Multi-cycle, fully pipelined word memory that answers the CPU/cache side's `enable`/`wr`/`addr`/`data_in` requests. It accepts one request per cycle and returns read data a fixed `LATENCY` cycles later, with a `data_valid` strobe and an echoed tag. It replaces the single-cycle data memory behind the pipeline and is the backing store for the upcoming cache-fill controller, which issues back-to-back word reads and matches returns by tag.

---
 rtl/pipelined_data_mem_pkg.sv | 16 +
 rtl/pipelined_data_mem_pipe_stage.sv | 37 +++
 rtl/pipelined_data_mem.sv | 93 +++++++++
 tb/tb_pipelined_data_mem.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_data_mem_pkg.sv
// Shared memory-request definitions for the data memory and the cache-fill controller.
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_TAG_W  = 2;

  typedef struct packed {
    logic                  enable;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic [MEM_TAG_W-1:0]  tag;
  } mem_req_t;

endpackage

// File: rtl/pipelined_data_mem_pipe_stage.sv
// One {valid, data, tag} stage of the read-response pipeline; fields are zeroed when empty.
module mem_pipe_stage #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [TAG_W-1:0]  r_tag;

  // Empty stages carry zeros so the last stage can drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_tag   <= '0;
    end else begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
      r_tag   <= i_valid ? i_tag  : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_tag   = r_tag;

endmodule

// File: rtl/pipelined_data_mem.sv
// Fully pipelined word memory: one request per cycle, read data returned LATENCY cycles later.
module pipelined_data_mem
  import mem_pkg::*;
#(
  parameter int DATA_W  = MEM_DATA_W,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DEPTH   = 32768,
  parameter int LATENCY = 4,
  parameter int TAG_W   = MEM_TAG_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       wr,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [TAG_W-1:0]           tag_in,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic [TAG_W-1:0]           tag_out,
  output logic [$clog2(LATENCY):0]   pending
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PEND_W = $clog2(LATENCY) + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PEND_W-1:0] r_pending;

  logic [IDX_W-1:0]  w_idx;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [ADDR_W-1:0] w_unused_addr;

  logic              w_valid [LATENCY+1];
  logic [DATA_W-1:0] w_data  [LATENCY+1];
  logic [TAG_W-1:0]  w_tag   [LATENCY+1];

  // Byte bit 0 and index bits above the array size are deliberately dropped.
  assign w_idx         = addr[IDX_W:1];
  assign w_unused_addr = addr;
  assign w_rd_acc      = enable & ~wr;
  assign w_wr_acc      = enable & wr & rst_n;

  // Array is never reset; writes are simply gated off while reset is held.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Stage 1 samples the array at the accepting edge, so a write one edge earlier is seen.
  assign w_valid[0] = w_rd_acc;
  assign w_data[0]  = r_mem[w_idx];
  assign w_tag[0]   = tag_in;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      mem_pipe_stage #(
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_valid[gi]),
        .i_data  (w_data[gi]),
        .i_tag   (w_tag[gi]),
        .o_valid (w_valid[gi+1]),
        .o_data  (w_data[gi+1]),
        .o_tag   (w_tag[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      case ({w_rd_acc, w_valid[LATENCY]})
        2'b10:   r_pending <= r_pending + PEND_W'(1);
        2'b01:   r_pending <= r_pending - PEND_W'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign data_out   = w_data[LATENCY];
  assign data_valid = w_valid[LATENCY];
  assign tag_out    = w_tag[LATENCY];
  assign pending    = r_pending;

endmodule

// File: tb/tb_pipelined_data_mem.sv
// Bench for pipelined_data_mem: directed scenarios plus random traffic against a queue-based model.
module tb_pipelined_data_mem;

  localparam int DEPTH   = 32768;
  localparam int LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [1:0]  tag_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [1:0]  tag_out;
  logic [2:0]  pending;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  tag;
    int          due;
  } resp_t;

  resp_t       exp_q[$];
  logic [15:0] mdl_mem [int];

  pipelined_data_mem #(
    .DATA_W  (16),
    .ADDR_W  (16),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY),
    .TAG_W   (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .wr         (wr),
    .addr       (addr),
    .data_in    (data_in),
    .tag_in     (tag_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .tag_out    (tag_out),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int word_of(input logic [15:0] a);
    return int'(a >> 1) % DEPTH;
  endfunction

  // Addresses for random traffic: 32 words spread across both halves of the index space.
  function automatic logic [15:0] pool_addr(input int i, input logic b0);
    logic [4:0] s;
    s = 5'(i);
    return {s[4], 10'b0, s[3:0], b0};
  endfunction

  // Model: reads capture the word at acceptance and are due LATENCY-1 cycles later.
  int mdl_w;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && enable) begin
      mdl_w = word_of(addr);
      if (wr) mdl_mem[mdl_w] = data_in;
      else exp_q.push_back('{mdl_mem.exists(mdl_w) ? mdl_mem[mdl_w] : 16'h0, tag_in, cyc + LATENCY - 1});
    end
  end

  always @(negedge rst_n) exp_q.delete();

  logic        exp_v;
  logic [15:0] exp_d;
  logic [1:0]  exp_t;
  always @(negedge clk) begin
    exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    exp_d = exp_v ? exp_q[0].data : 16'h0;
    exp_t = exp_v ? exp_q[0].tag : 2'd0;
    chk("pending", 32'(pending), 32'(exp_q.size()));
    chk("response", 32'({data_valid, tag_out, data_out}), 32'({exp_v, exp_t, exp_d}));
    if (exp_v) begin
      $display("resp cycle=%0d tag=%0d data=0x%04h", cyc, tag_out, data_out);
      void'(exp_q.pop_front());
    end
  end

  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] t);
    enable  = 1'b1;
    wr      = w;
    addr    = a;
    data_in = d;
    tag_in  = t;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wr     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int seen;
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",   32'(data_valid), 0);
    chk("rst_data",    32'(data_out),   0);
    chk("rst_tag",     32'(tag_out),    0);
    chk("rst_pending", 32'(pending),    0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) req(1'b1, pool_addr(i, 1'b0), 16'($urandom), 2'd0);

    // Write, then read the same word (odd byte address) on the next cycle.
    req(1'b1, 16'h0010, 16'hBEEF, 2'd0);
    req(1'b0, 16'h0011, 16'h0, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wr_rd_not_early", 32'(data_valid), 0);
    @(posedge clk);
    @(negedge clk);
    chk("wr_rd_valid", 32'(data_valid), 1);
    chk("wr_rd_data",  32'(data_out),   32'hBEEF);
    chk("wr_rd_tag",   32'(tag_out),    2);
    idle(2);

    // Burst of four back-to-back reads.
    for (int i = 0; i < 4; i++) req(1'b1, 16'(16'h20 + 2 * i), 16'(i + 1), 2'd0);
    for (int i = 0; i < 4; i++) req(1'b0, 16'(16'h20 + 2 * i), 16'h0, 2'(i));
    @(negedge clk);
    chk("burst_peak_pending", 32'(pending), 4);
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", 32'(data_valid), 1);
      chk("burst_data",  32'(data_out),   32'(i + 1));
      chk("burst_tag",   32'(tag_out),    32'(i));
      @(negedge clk);
    end
    chk("burst_drain_pending", 32'(pending),    0);
    chk("burst_drain_valid",   32'(data_valid), 0);
    idle(1);

    // Index is addr[15:1]: 0x0004 and 0x8004 are distinct words; addr[0] is ignored.
    req(1'b1, 16'h0004, 16'h1234, 2'd0);
    req(1'b1, 16'h8004, 16'h5678, 2'd0);
    req(1'b0, 16'h8004, 16'h0, 2'd1);
    req(1'b0, 16'h0005, 16'h0, 2'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("addr_hi_data", 32'(data_out), 32'h5678);
    chk("addr_hi_tag",  32'(tag_out),  1);
    @(negedge clk);
    chk("addr_lo_data", 32'(data_out), 32'h1234);
    chk("addr_lo_tag",  32'(tag_out),  3);
    idle(2);

    // Alternate write/read to one word.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) req(1'b1, 16'h0040, 16'(16'hA000 + i), 2'd0);
      else            req(1'b0, 16'h0041, 16'h0, 2'(i / 2));
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("interleave_last_data", 32'(data_out), 32'hA006);
    chk("interleave_last_tag",  32'(tag_out),  3);
    idle(2);

    // Reset while three reads are in flight; a write presented during reset is dropped.
    req(1'b1, 16'h0060, 16'h1111, 2'd0);
    req(1'b0, 16'h0020, 16'h0, 2'd1);
    req(1'b0, 16'h0022, 16'h0, 2'd2);
    req(1'b0, 16'h0024, 16'h0, 2'd3);
    rst_n   = 1'b0;
    enable  = 1'b1;
    wr      = 1'b1;
    addr    = 16'h0060;
    data_in = 16'hDEAD;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b0;
    wr     = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_valid) seen++;
    end
    chk("flush_no_response", 32'(seen),    0);
    chk("flush_pending",     32'(pending), 0);
    idle(1);
    req(1'b0, 16'h0060, 16'h0, 2'd1);
    req(1'b0, 16'h0020, 16'h0, 2'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_reset_word_kept",  32'(data_out), 32'h1111);
    @(negedge clk);
    chk("post_reset_burst_kept", 32'(data_out), 32'h0001);
    idle(2);

    // Random traffic over the preloaded address pool.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7)
        req($urandom_range(0, 1) == 1,
            pool_addr(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1))),
            16'($urandom), 2'($urandom_range(0, 3)));
      else
        idle(1);
    end
    idle(LATENCY + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
